// File: rtl/hazard_scoreboard_if.sv
// Decode-to-scoreboard bundle: instruction in decode, flush, and the stall/issue/status outputs.
// The master side is the decode stage; the slave side is hazard_scoreboard.
interface hazard_scoreboard_if #(
    parameter int DEPTH = 3,
    parameter int CNT_W = 16
);
    logic [15:0]      id_inst;
    logic             id_valid;
    logic             flush;
    logic             stall;
    logic             issue;
    logic [DEPTH-1:0] inflight;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_inst, id_valid, flush,
        input  stall, issue, inflight, stall_cnt
    );

    modport slave (
        input  id_inst, id_valid, flush,
        output stall, issue, inflight, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard for a DEPTH-stage in-order pipeline; HAZARD_SCOREBOARD_FWD_EN limits stalls to load-use.
// stall/issue are combinational from decode and tracked entries; entries and stall_cnt update every edge.
module hazard_scoreboard #(
    parameter int DEPTH = 3,
    parameter int REG_W = 3,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    hazard_scoreboard_if.slave  sb
);
    typedef struct packed {
        logic             vld;
        logic             dvld;
        logic [REG_W-1:0] dest;
        logic             load;
    } entry_t;

    entry_t           r_ent [DEPTH];
    logic [CNT_W-1:0] r_stall_cnt;

    logic [4:0]       w_op;
    logic             w_s1_vld;
    logic             w_s2_vld;
    logic             w_d_vld;
    logic             w_is_load;
    logic [REG_W-1:0] w_src1;
    logic [REG_W-1:0] w_src2;
    logic [REG_W-1:0] w_dest;
    logic [DEPTH-1:0] w_match;
    logic             w_hazard;
    logic             w_live;
    entry_t           w_new;

    assign w_op   = sb.id_inst[15:11];
    assign w_src1 = REG_W'(sb.id_inst[10:8]);
    assign w_src2 = REG_W'(sb.id_inst[7:5]);

    always_comb begin
        w_s1_vld  = 1'b0;
        w_s2_vld  = 1'b0;
        w_d_vld   = 1'b0;
        w_is_load = 1'b0;
        w_dest    = '0;
        casez (w_op)
            5'b1101?, 5'b111??, 5'b11001: begin
                w_s1_vld = 1'b1;
                w_s2_vld = 1'b1;
                w_d_vld  = 1'b1;
                w_dest   = REG_W'(sb.id_inst[4:2]);
            end
            5'b010??, 5'b101??: begin
                w_s1_vld = 1'b1;
                w_d_vld  = 1'b1;
                w_dest   = REG_W'(sb.id_inst[7:5]);
            end
            5'b10001: begin
                w_s1_vld  = 1'b1;
                w_d_vld   = 1'b1;
                w_is_load = 1'b1;
                w_dest    = REG_W'(sb.id_inst[7:5]);
            end
            5'b10011, 5'b10010: begin
                w_s1_vld = 1'b1;
                w_d_vld  = 1'b1;
                w_dest   = REG_W'(sb.id_inst[10:8]);
            end
            5'b11000: begin
                w_d_vld = 1'b1;
                w_dest  = REG_W'(sb.id_inst[10:8]);
            end
            5'b10000, 5'b00101, 5'b011??: begin
                w_s1_vld = 1'b1;
            end
            // Link-register ops: 00111 both reads a source and writes r7.
            5'b00111: begin
                w_s1_vld = 1'b1;
                w_d_vld  = 1'b1;
                w_dest   = '1;
            end
            5'b00110: begin
                w_d_vld = 1'b1;
                w_dest  = '1;
            end
            default: begin
                w_s1_vld = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_match = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_match[k] = r_ent[k].vld & r_ent[k].dvld &
                         ((w_s1_vld & (r_ent[k].dest == w_src1)) |
                          (w_s2_vld & (r_ent[k].dest == w_src2)));
        end
    end

`ifdef HAZARD_SCOREBOARD_FWD_EN
    // Everything but a load still in its first stage can be bypassed.
    assign w_hazard = w_match[0] & r_ent[0].load;
`else
    assign w_hazard = |w_match;
`endif

    assign w_live    = sb.id_valid & ~sb.flush & ~rst;
    assign sb.stall  = w_live & w_hazard;
    assign sb.issue  = w_live & ~w_hazard;

    assign w_new = '{vld: 1'b1, dvld: w_d_vld, dest: w_dest, load: w_is_load};

    always_ff @(posedge clk) begin
        if (rst || sb.flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_ent[k] <= '0;
            end
        end else begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                r_ent[k] <= r_ent[k-1];
            end
            r_ent[0] <= sb.issue ? w_new : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (sb.stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        sb.inflight = '0;
        for (int k = 0; k < DEPTH; k++) begin
            sb.inflight[k] = r_ent[k].vld;
        end
    end

    assign sb.stall_cnt = r_stall_cnt;
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter DEPTH, default 3: number of in-flight pipeline stages tracked after decode.
REQ-002 SHALL have parameter REG_W, default 3: register index width (2^REG_W architectural registers).
REQ-003 SHALL have parameter CNT_W, default 16: stall counter width.
REQ-004 SHALL have one clock and a synchronous active-high reset.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port rst  input  1  synchronous active-high reset.
REQ-007 SHALL have port id_inst  input  16  instruction in decode.
REQ-008 SHALL have port id_valid  input  1  id_inst holds a real instruction.
REQ-009 SHALL have port flush  input  1  squash decode and all tracked entries (taken branch/jump).
REQ-010 SHALL have port stall  output  1  hold fetch/decode, inject bubble.
REQ-011 SHALL have port issue  output  1  id_valid & ~stall & ~flush.
REQ-012 SHALL have port inflight  output  DEPTH  valid mask of tracked entries, bit k = entry k.
REQ-013 SHALL have port stall_cnt  output  CNT_W  saturating count of stall cycles.

Function
REQ-014 SHALL decode sources by opcode id_inst[15:11]: 1101x, 111xx, 11001 -> src1=[10:8], src2=[7:5]; 010xx, 101xx, 10000, 10001, 10011, 10010, 001x1, 011xx -> src1=[10:8] only; all others -> no source.
REQ-015 SHALL decode destination: 1101x, 111xx, 11001 -> [4:2]; 010xx, 101xx, 10001 -> [7:5]; 10011, 11000, 10010 -> [10:8]; 0011x -> register 7; all others -> no destination.
REQ-016 SHALL carry explicit valid bits for every source and destination; a missing operand never matches.
REQ-017 SHALL hold DEPTH entries {valid, dest_valid, dest, is_load}; is_load set for opcode 10001.
REQ-018 SHALL each cycle shift entry k-1 -> k and load entry 0 with the decoded instruction when issue=1, else with a bubble (valid=0).
REQ-019 SHALL drive stall combinationally from current entries and id_inst; stall=0 when id_valid=0, flush=1 or rst=1.
REQ-020 SHALL (base mode) assert stall if any entry k with valid & dest_valid has dest equal to a valid source.
REQ-021 SHALL cause a consumer whose youngest matching producer sits in entry k to stall exactly DEPTH-k cycles, then issue.
REQ-022 SHALL on flush=1 clear all entries at the next edge, ignoring the shift; decode instruction is not recorded.
REQ-023 SHALL increment stall_cnt on every cycle stall=1 and saturate at all-ones.
REQ-024 SHALL make inflight a registered view of entry valid bits (no combinational path from inputs).

Reset
REQ-025 SHALL on rst=1 at a clock edge clear all entries (inflight=0) and set stall_cnt=0.
REQ-026 SHALL keep stall=0 and issue=0 while rst=1; rst mid-stall aborts the stall and the waiting instruction is re-evaluated against empty entries.

Configuration
REQ-027 SHALL honour macro HAZARD_SCOREBOARD_FWD_EN: when defined, stall only if entry 0 is a valid load whose dest matches a valid source (1-cycle load-use stall); all other RAW hazards are assumed bypassed.
REQ-028 SHALL, without HAZARD_SCOREBOARD_FWD_EN, apply REQ-020 across all DEPTH entries; interface identical in both builds.

Verification
REQ-029 SHALL cover: DEPTH=3, no FWD: 16'h4220 (ADDI r1,r2) then 16'hD98C (ADD r3,r1,r4) -> stall=1 for 3 cycles, issue on 4th, stall_cnt=3.
REQ-030 SHALL cover: FWD build, 16'h8A20 (LD r1,[r2]) then 16'hD98C -> stall 1 cycle; 16'h4220 then 16'hD98C -> 0 stalls.
REQ-031 SHALL cover: no FWD, 16'h3000 (JAL) then 16'h2F00 (JR r7) -> 3 stall cycles; 16'h4220 then ADD r3,r5,r6 -> 0 stalls.
REQ-032 SHALL cover: 16'h4220 issued, 16'hD98C stalled, flush=1 next cycle -> stall=0 that cycle, inflight=0 after edge, re-presented D98C issues with no stall.
REQ-033 SHALL cover: CNT_W=4, 20 stall cycles -> stall_cnt=15; rst asserted during a stall -> stall=0, stall_cnt=0, inflight=0 next cycle.
